// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential PC reads against a fixed-latency memory and
// buffers returned words with their PCs for a valid/ready decode consumer.
module fetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     halt,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_tgt,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_instr,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [PtrW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [MEM_LAT-1:0] fl_vld_q, fl_vld_d;
  logic [ADDR_W-1:0]  fl_pc_q [MEM_LAT];
  logic [ADDR_W-1:0]  fl_pc_d [MEM_LAT];
  logic [DATA_W-1:0]  data_q [DEPTH];
  logic [ADDR_W-1:0]  tag_q [DEPTH];

  logic [31:0] credits_used;
  logic        issue, land, pop;

  // Queued entries plus every read still in flight each hold a reserved slot.
  always_comb begin
    credits_used = 32'(cnt_q);
    for (int i = 0; i < MEM_LAT; i++) begin
      credits_used = credits_used + 32'(fl_vld_q[i]);
    end
  end

  assign out_valid = (cnt_q != '0);
  assign issue     = !rst && !halt && !redirect && (credits_used < DEPTH);
  assign land      = fl_vld_q[MEM_LAT-1] && !redirect && !rst;
  assign pop       = out_valid && out_ready && !halt && !redirect;

  assign mem_req   = issue;
  assign mem_addr  = pc_q;
  assign out_instr = data_q[rptr_q];
  assign out_pc    = tag_q[rptr_q];
  assign occupancy = cnt_q;

  always_comb begin
    pc_d        = pc_q;
    wptr_d      = wptr_q + PtrW'(land);
    rptr_d      = rptr_q + PtrW'(pop);
    cnt_d       = cnt_q + CntW'(land) - CntW'(pop);
    fl_vld_d[0] = issue;
    fl_pc_d[0]  = pc_q;
    for (int i = 1; i < MEM_LAT; i++) begin
      fl_vld_d[i] = fl_vld_q[i-1];
      fl_pc_d[i]  = fl_pc_q[i-1];
    end
    if (issue) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
    if (redirect) begin
      pc_d     = redirect_tgt;
      wptr_d   = '0;
      rptr_d   = '0;
      cnt_d    = '0;
      fl_vld_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      fl_vld_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        fl_pc_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      fl_vld_q <= fl_vld_d;
      for (int i = 0; i < MEM_LAT; i++) begin
        fl_pc_q[i] <= fl_pc_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (land) begin
      data_q[wptr_q] <= mem_data;
      tag_q[wptr_q]  <= fl_pc_q[MEM_LAT-1];
    end
  end

  // Credit reservation must make a landing into a full queue impossible.
  assert property (@(posedge clk) disable iff (rst) !(land && (cnt_q == CntW'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: cycle table plus scoreboard on the default instance, and a
// wrap-around check on a deep, long-latency instance.
module tb_fetch_queue;

  localparam logic [31:0] Key = 32'hA5A5A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: DEPTH=4, MEM_LAT=1, RESET_PC=0.
  logic        rst_a, halt_a, redir_a, req_a, valid_a, ready_a;
  logic [31:0] tgt_a, addr_a, data_a, instr_a, pc_a, ap_a;
  logic [2:0]  occ_a;

  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .MEM_LAT(1), .RESET_PC(32'h0),
                .PC_STEP(4)) u_dut_a (
    .clk(clk), .rst(rst_a), .halt(halt_a), .redirect(redir_a), .redirect_tgt(tgt_a),
    .mem_req(req_a), .mem_addr(addr_a), .mem_data(data_a), .out_valid(valid_a),
    .out_ready(ready_a), .out_instr(instr_a), .out_pc(pc_a), .occupancy(occ_a)
  );

  always @(posedge clk) ap_a <= addr_a;
  assign data_a = ap_a ^ Key;

  // Instance B: DEPTH=8, MEM_LAT=3, RESET_PC=FFFFFFF8.
  logic        rst_b, req_b, valid_b;
  logic [31:0] addr_b, data_b, instr_b, pc_b;
  logic [31:0] bp [3];
  logic [3:0]  occ_b;

  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(8), .MEM_LAT(3), .RESET_PC(32'hFFFF_FFF8),
                .PC_STEP(4)) u_dut_b (
    .clk(clk), .rst(rst_b), .halt(1'b0), .redirect(1'b0), .redirect_tgt(32'h0),
    .mem_req(req_b), .mem_addr(addr_b), .mem_data(data_b), .out_valid(valid_b),
    .out_ready(1'b1), .out_instr(instr_b), .out_pc(pc_b), .occupancy(occ_b)
  );

  always @(posedge clk) begin
    bp[0] <= addr_b;
    bp[1] <= bp[0];
    bp[2] <= bp[1];
  end
  assign data_b = bp[2] ^ Key;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard for A: every issued address is owed back, in order, unless flushed.
  logic [31:0] sb_q [$];
  always @(negedge clk) begin
    if (rst_a || redir_a) begin
      sb_q.delete();
    end else begin
      check("sb mem_req credit", 64'(req_a), 64'(!halt_a && (sb_q.size() < 4)));
      if (valid_a && ready_a && !halt_a) begin
        if (sb_q.size() == 0) begin
          check("sb pop with nothing owed", 64'(valid_a), 64'(0));
        end else begin
          logic [31:0] e;
          e = sb_q.pop_front();
          check("sb out_pc", 64'(pc_a), 64'(e));
          check("sb out_instr", 64'(instr_a), 64'(e ^ Key));
        end
      end
      if (req_a) sb_q.push_back(addr_a);
    end
  end

  typedef struct {
    logic        halt;
    logic        redir;
    logic [31:0] tgt;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [2:0]  exp_occ;
  } vec_t;

  function automatic vec_t v(input logic h, input logic r, input logic [31:0] t, input logic rd,
                             input logic q, input logic [31:0] a, input logic vl,
                             input logic [31:0] p, input logic [2:0] o);
    vec_t x;
    x = '{halt: h, redir: r, tgt: t, ready: rd, exp_req: q, exp_addr: a, exp_valid: vl,
          exp_pc: p, exp_occ: o};
    return x;
  endfunction

  vec_t tbl [$];

  initial begin
    // Streaming, back-pressure, release, redirect, halt.
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h00, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h04, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h08, 1, 32'h00, 1));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h0C, 1, 32'h04, 1));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h10, 1, 32'h08, 1));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h14, 1, 32'h0C, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'h18, 1, 32'h10, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'h1C, 1, 32'h10, 2));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h20, 1, 32'h10, 3));
    for (int i = 0; i < 7; i++) tbl.push_back(v(0, 0, 0, 0, 0, 32'h20, 1, 32'h10, 4));
    tbl.push_back(v(0, 0, 0, 1, 0, 32'h20, 1, 32'h10, 4));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h20, 1, 32'h14, 3));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h24, 1, 32'h18, 2));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h28, 1, 32'h1C, 2));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'h2C, 1, 32'h20, 2));
    tbl.push_back(v(0, 1, 32'h100, 1, 0, 32'h30, 1, 32'h20, 3));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h100, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h104, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h108, 1, 32'h100, 1));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h10C, 1, 32'h104, 1));
    tbl.push_back(v(1, 0, 0, 1, 0, 32'h110, 1, 32'h108, 1));
    tbl.push_back(v(1, 0, 0, 1, 0, 32'h110, 1, 32'h108, 2));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h110, 1, 32'h108, 2));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h114, 1, 32'h10C, 1));

    rst_a = 1; halt_a = 0; redir_a = 0; tgt_a = 0; ready_a = 1; rst_b = 1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset mem_req", 64'(req_a), 64'(0));
    check("reset mem_addr", 64'(addr_a), 64'(0));
    check("reset out_valid", 64'(valid_a), 64'(0));
    check("reset occupancy", 64'(occ_a), 64'(0));
    @(posedge clk);
    #1;
    rst_a = 0;

    for (int i = 0; i < tbl.size(); i++) begin
      halt_a  = tbl[i].halt;
      redir_a = tbl[i].redir;
      tgt_a   = tbl[i].tgt;
      ready_a = tbl[i].ready;
      @(negedge clk);
      check($sformatf("row%0d mem_req", i), 64'(req_a), 64'(tbl[i].exp_req));
      check($sformatf("row%0d mem_addr", i), 64'(addr_a), 64'(tbl[i].exp_addr));
      check($sformatf("row%0d out_valid", i), 64'(valid_a), 64'(tbl[i].exp_valid));
      check($sformatf("row%0d occupancy", i), 64'(occ_a), 64'(tbl[i].exp_occ));
      if (tbl[i].exp_valid) begin
        check($sformatf("row%0d out_pc", i), 64'(pc_a), 64'(tbl[i].exp_pc));
        check($sformatf("row%0d out_instr", i), 64'(instr_a), 64'(tbl[i].exp_pc ^ Key));
      end
      @(posedge clk);
      #1;
    end

    // Reset mid-stream together with a redirect: reset wins.
    halt_a = 0; ready_a = 1; rst_a = 1; redir_a = 1; tgt_a = 32'h200;
    @(negedge clk);
    check("rst+redir mem_req", 64'(req_a), 64'(0));
    @(posedge clk);
    #1;
    redir_a = 0;
    @(negedge clk);
    check("rst held mem_req", 64'(req_a), 64'(0));
    check("rst held pc", 64'(addr_a), 64'(0));
    check("rst held occupancy", 64'(occ_a), 64'(0));
    check("rst held out_valid", 64'(valid_a), 64'(0));
    @(posedge clk);
    #1;
    rst_a = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post-rst%0d mem_addr", i), 64'(addr_a), 64'(4 * i));
      check($sformatf("post-rst%0d out_valid", i), 64'(valid_a), 64'(i == 2));
      @(posedge clk);
      #1;
    end

    // Instance B: long latency and PC wrap.
    rst_b = 0;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ea, ep;
      ea = 32'hFFFF_FFF8 + 32'(4 * i);
      ep = 32'hFFFF_FFF8 + 32'(4 * (i - 4));
      @(negedge clk);
      check($sformatf("B%0d mem_req", i), 64'(req_b), 64'(1));
      check($sformatf("B%0d mem_addr", i), 64'(addr_b), 64'(ea));
      check($sformatf("B%0d out_valid", i), 64'(valid_b), 64'(i >= 4));
      if (i >= 4) begin
        check($sformatf("B%0d out_pc", i), 64'(pc_b), 64'(ep));
        check($sformatf("B%0d out_instr", i), 64'(instr_b), 64'(ep ^ Key));
        check($sformatf("B%0d occupancy", i), 64'(occ_b), 64'(1));
      end
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
